// File: rtl/psum_writeback.sv
// psum_writeback
//   Receives per-row partial sums from the PE-array controller and captures each valid
//   {address, psum} pair into a small per-row FIFO. The FIFOs drain round-robin through
//   a registered BRAM write port that uses a valid/ready handshake. A pass starts on
//   'start'. After 'last', the block flushes every captured psum and then pulses 'drained'.
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   start         : one-cycle pulse that begins a collection pass (honoured only when idle)
//   last          : one-cycle pulse; no further psums follow in this pass
//   psums_in      : row i psum at [i*PSUM_W +: PSUM_W]
//   psum_valid    : per-row valid for psums_in / psum_addr
//   psum_addr     : row i address at [i*ADDR_W +: ADDR_W]
//   mem_wr_en     : registered write request
//   mem_wr_addr   : registered write address
//   mem_wr_data   : registered write data
//   mem_wr_ready  : BRAM accept; a transfer happens on mem_wr_en && mem_wr_ready
//   busy          : high while collecting or flushing
//   drained       : one-cycle pulse when a pass has completed
//   overflow      : sticky; a psum was dropped (full FIFO, or valid during flush)
//   words_written : transfers completed in this pass (wraps at 2^16)

module psum_writeback #(
  parameter int unsigned ARRAY_ROWS = 3,
  parameter int unsigned PSUM_W     = 48,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         last,
  input  logic [ARRAY_ROWS*PSUM_W-1:0] psums_in,
  input  logic [ARRAY_ROWS-1:0]        psum_valid,
  input  logic [ARRAY_ROWS*ADDR_W-1:0] psum_addr,
  output logic                         mem_wr_en,
  output logic [ADDR_W-1:0]            mem_wr_addr,
  output logic [PSUM_W-1:0]            mem_wr_data,
  input  logic                         mem_wr_ready,
  output logic                         busy,
  output logic                         drained,
  output logic                         overflow,
  output logic [15:0]                  words_written
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RR_W  = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;

  typedef enum logic [1:0] {StIdle, StCollect, StFlush, StDone} state_e;

  state_e r_state, w_state_next;

  // Per-row FIFO status and handshake
  logic [ARRAY_ROWS-1:0] w_empty;
  logic [ARRAY_ROWS-1:0] w_full;
  logic [ARRAY_ROWS-1:0] w_push_req;
  logic [ARRAY_ROWS-1:0] w_push;
  logic [ARRAY_ROWS-1:0] w_pop;
  logic [ARRAY_ROWS-1:0] w_drop;
  logic [ADDR_W-1:0]     w_head_addr [ARRAY_ROWS];
  logic [PSUM_W-1:0]     w_head_data [ARRAY_ROWS];

  // Arbiter / output register
  logic [RR_W-1:0]   r_rr;
  logic [RR_W-1:0]   w_winner;
  logic [RR_W-1:0]   w_rr_next;
  logic              w_any;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [PSUM_W-1:0] w_sel_data;
  logic              w_load;
  logic              w_xfer;
  logic              r_mem_wr_en;
  logic [ADDR_W-1:0] r_mem_wr_addr;
  logic [PSUM_W-1:0] r_mem_wr_data;

  // Status
  logic        r_overflow;
  logic [15:0] r_words;
  logic        w_collect;
  logic        w_busy;

  assign w_collect = (r_state == StCollect);
  assign w_busy    = (r_state == StCollect) || (r_state == StFlush);

  // The output slot may be refilled whenever it is empty or is being consumed this cycle.
  assign w_load = !r_mem_wr_en || mem_wr_ready;
  assign w_xfer = r_mem_wr_en && mem_wr_ready;

  // ---------------------------------------------------------------------------------------
  // Per-row FIFOs
  // ---------------------------------------------------------------------------------------
  for (genvar gi = 0; gi < ARRAY_ROWS; gi++) begin : g_row
    logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
    logic [PSUM_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    assign w_empty[gi]    = (r_count == '0);
    assign w_full[gi]     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push_req[gi] = w_collect && psum_valid[gi];
    assign w_pop[gi]      = w_load && w_any && (w_winner == RR_W'(gi));
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign w_push[gi]     = w_push_req[gi] && (!w_full[gi] || w_pop[gi]);
    assign w_drop[gi]     = w_push_req[gi] && w_full[gi] && !w_pop[gi];

    assign w_head_addr[gi] = r_mem_addr[r_rd_ptr];
    assign w_head_data[gi] = r_mem_data[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[gi]) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push[gi], w_pop[gi]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    // Storage needs no reset; emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
      if (w_push[gi]) begin
        r_mem_addr[r_wr_ptr] <= psum_addr[gi*ADDR_W +: ADDR_W];
        r_mem_data[r_wr_ptr] <= psums_in[gi*PSUM_W +: PSUM_W];
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Round-robin arbiter: first non-empty row scanning r_rr, r_rr+1, ... with wrap.
  // Scanning from the farthest offset down lets the nearest candidate win by overwriting.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    int unsigned     scan_t;
    logic [RR_W-1:0] idx;
    scan_t     = 0;
    idx        = '0;
    w_any      = 1'b0;
    w_winner   = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned k = 0; k < ARRAY_ROWS; k++) begin
      scan_t = (32'(r_rr) + ARRAY_ROWS - 1 - k) % ARRAY_ROWS;
      idx    = RR_W'(scan_t);
      if (!w_empty[idx]) begin
        w_any      = 1'b1;
        w_winner   = idx;
        w_sel_addr = w_head_addr[idx];
        w_sel_data = w_head_data[idx];
      end
    end
  end

  assign w_rr_next = (w_winner == RR_W'(ARRAY_ROWS - 1)) ? '0 : w_winner + 1'b1;

  // ---------------------------------------------------------------------------------------
  // Registered write port
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
      r_rr          <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_mem_wr_en   <= 1'b1;
        r_mem_wr_addr <= w_sel_addr;
        r_mem_wr_data <= w_sel_data;
        r_rr          <= w_rr_next;
      end else begin
        r_mem_wr_en <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Pass control FSM
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (start) w_state_next = StCollect;
      StCollect: if (last)  w_state_next = StFlush;
      // Done only once nothing is queued and the output slot has been consumed.
      StFlush:   if ((&w_empty) && !r_mem_wr_en) w_state_next = StDone;
      StDone:    w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Pass status
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_words    <= '0;
    end else if ((r_state == StIdle) && start) begin
      r_overflow <= 1'b0;
      r_words    <= '0;
    end else begin
      if ((|w_drop) || ((r_state == StFlush) && (|psum_valid))) r_overflow <= 1'b1;
      if (w_xfer && w_busy) r_words <= r_words + 16'd1;
    end
  end

  assign mem_wr_en     = r_mem_wr_en;
  assign mem_wr_addr   = r_mem_wr_addr;
  assign mem_wr_data   = r_mem_wr_data;
  assign busy          = w_busy;
  assign drained       = (r_state == StDone);
  assign overflow      = r_overflow;
  assign words_written = r_words;

endmodule

// File: tb/tb_psum_writeback.sv
// tb_psum_writeback
//   Scoreboard bench for psum_writeback. A queue-based reference model predicts every
//   write and the status outputs; a negedge monitor compares the DUT against it.
//   Directed scenarios come first, followed by randomized passes.

module tb_psum_writeback;

  localparam int unsigned ROWS  = 3;
  localparam int unsigned PW    = 48;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;

  typedef logic [AW+PW-1:0] ent_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 last;
  logic [ROWS*PW-1:0]   psums_in;
  logic [ROWS-1:0]      psum_valid;
  logic [ROWS*AW-1:0]   psum_addr;
  logic                 mem_wr_en;
  logic [AW-1:0]        mem_wr_addr;
  logic [PW-1:0]        mem_wr_data;
  logic                 mem_wr_ready;
  logic                 busy;
  logic                 drained;
  logic                 overflow;
  logic [15:0]          words_written;

  psum_writeback #(
    .ARRAY_ROWS(ROWS),
    .PSUM_W    (PW),
    .ADDR_W    (AW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .last         (last),
    .psums_in     (psums_in),
    .psum_valid   (psum_valid),
    .psum_addr    (psum_addr),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ready (mem_wr_ready),
    .busy         (busy),
    .drained      (drained),
    .overflow     (overflow),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------------------
  // Reference model: per-row queues, one output slot, pass phase 0..3 (idle/collect/
  // flush/done). Advances on each clock edge using the inputs that were stable before it.
  // ---------------------------------------------------------------------------------------
  ent_t        mq [ROWS][$];
  ent_t        exp_q[$];
  int          m_st    = 0;
  logic        m_en    = 1'b0;
  ent_t        m_slot  = '0;
  int          m_rr    = 0;
  logic        m_ovf   = 1'b0;
  logic [15:0] m_words = '0;

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) mq[r].delete();
    exp_q.delete();
    m_st = 0; m_en = 1'b0; m_slot = '0; m_rr = 0; m_ovf = 1'b0; m_words = '0;
  endtask

  task automatic model_step();
    bit all_empty;
    bit pre_en;
    int win;
    int r;
    all_empty = 1'b1;
    for (int i = 0; i < ROWS; i++) if (mq[i].size() != 0) all_empty = 1'b0;
    pre_en = m_en;
    if (m_en && mem_wr_ready && (m_st == 1 || m_st == 2)) m_words++;
    if (!m_en || mem_wr_ready) begin
      win = -1;
      for (int k = 0; k < ROWS; k++) begin
        r = (m_rr + k) % ROWS;
        if (win < 0 && mq[r].size() > 0) win = r;
      end
      if (win >= 0) begin
        m_slot = mq[win].pop_front();
        m_en   = 1'b1;
        m_rr   = (win + 1) % ROWS;
        exp_q.push_back(m_slot);
      end else begin
        m_en = 1'b0;
      end
    end
    if (m_st == 1) begin
      for (int i = 0; i < ROWS; i++) begin
        if (psum_valid[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back({psum_addr[i*AW +: AW], psums_in[i*PW +: PW]});
          else m_ovf = 1'b1;
        end
      end
    end
    if (m_st == 2 && psum_valid != '0) m_ovf = 1'b1;
    case (m_st)
      0: if (start) begin m_st = 1; m_ovf = 1'b0; m_words = '0; end
      1: if (last) m_st = 2;
      2: if (all_empty && !pre_en) m_st = 3;
      default: m_st = 0;
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_clear();
    else     model_step();
  end

  // ---------------------------------------------------------------------------------------
  // Monitor: compare on the falling edge, away from the active edge.
  // ---------------------------------------------------------------------------------------
  int            drained_cnt = 0;
  logic [AW-1:0] wr_log[$];
  ent_t          mon_e;

  initial forever begin
    @(negedge clk);
    check("wr_en", 80'(mem_wr_en), 80'(m_en));
    if (m_en) begin
      check("wr_addr_hold", 80'(mem_wr_addr), 80'(m_slot[PW +: AW]));
      check("wr_data_hold", 80'(mem_wr_data), 80'(m_slot[PW-1:0]));
    end
    check("busy", 80'(busy), 80'(m_st == 1 || m_st == 2));
    check("drained", 80'(drained), 80'(m_st == 3));
    check("overflow", 80'(overflow), 80'(m_ovf));
    check("words_written", 80'(words_written), 80'(m_words));
    if (drained) drained_cnt++;
    if (mem_wr_en && mem_wr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_write: got write addr=%0h data=%0h, expected no write (t=%0t)",
                 mem_wr_addr, mem_wr_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_write", {mem_wr_addr, mem_wr_data}, mon_e);
      end
      wr_log.push_back(mem_wr_addr);
    end
  end

  // ---------------------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; last = 1'b0; psum_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_row(input int r, input logic [AW-1:0] a, input logic [PW-1:0] d);
    psum_valid[r]         = 1'b1;
    psum_addr[r*AW +: AW] = a;
    psums_in[r*PW +: PW]  = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Waits for the drained pulse, then steps into idle. Optionally randomizes ready and
  // injects occasional late psums while flushing.
  task automatic wait_drained(input int budget, input bit rnd);
    int i;
    for (i = 0; i < budget && !drained; i++) begin
      if (rnd) begin
        mem_wr_ready = ($urandom_range(0, 3) != 0);
        psum_valid   = ($urandom_range(0, 19) == 0) ? ROWS'($urandom) : '0;
      end
      cyc();
    end
    if (!drained) begin
      n_checks++;
      n_errors++;
      $display("FAIL drained_timeout: drained=0 after %0d cycles, expected 1", budget);
    end
    psum_valid = '0;
    cyc();
  endtask

  int            base_log;
  int            base_dr;
  int            len;
  bit            seen77;
  logic [AW-1:0] ord_exp [6];

  initial begin
    rst          = 1'b1;
    mem_wr_ready = 1'b0;
    psums_in     = '0;
    psum_addr    = '0;
    clear_inputs();

    // Reset state
    do_reset();
    check("reset_en", 80'(mem_wr_en), 80'(0));
    check("reset_busy", 80'(busy), 80'(0));
    check("reset_words", 80'(words_written), 80'(0));

    // Single row, no stall: first write two edges after the push cycle
    mem_wr_ready = 1'b1;
    base_dr      = drained_cnt;
    pulse_start();
    set_row(0, 32'h10, 48'd1);
    cyc();
    check("lat_t1_en", 80'(mem_wr_en), 80'(0));
    set_row(0, 32'h11, 48'd2);
    cyc();
    check("lat_t2_en", 80'(mem_wr_en), 80'(1));
    check("lat_t2_addr", 80'(mem_wr_addr), 80'(32'h10));
    set_row(0, 32'h12, 48'd3);
    cyc();
    psum_valid = '0;
    last       = 1'b1;
    cyc();
    last = 1'b0;
    wait_drained(50, 1'b0);
    cyc();
    check("single_words", 80'(words_written), 80'(3));
    check("single_ovf", 80'(overflow), 80'(0));
    check("single_drained_once", 80'(drained_cnt - base_dr), 80'(1));

    // All rows in one cycle from rr = 0, twice
    do_reset();
    mem_wr_ready = 1'b1;
    base_log     = wr_log.size();
    ord_exp[0] = 32'h000; ord_exp[1] = 32'h100; ord_exp[2] = 32'h200;
    ord_exp[3] = 32'h300; ord_exp[4] = 32'h400; ord_exp[5] = 32'h500;
    pulse_start();
    for (int r = 0; r < ROWS; r++) set_row(r, ord_exp[r], 48'(r + 20));
    cyc();
    psum_valid = '0;
    repeat (6) cyc();
    for (int r = 0; r < ROWS; r++) set_row(r, ord_exp[r+3], 48'(r + 30));
    cyc();
    psum_valid = '0;
    last       = 1'b1;
    cyc();
    last = 1'b0;
    wait_drained(50, 1'b0);
    check("rr_count", 80'(wr_log.size() - base_log), 80'(6));
    for (int i = 0; i < 6; i++) begin
      if (base_log + i < wr_log.size()) check("rr_order", 80'(wr_log[base_log+i]), 80'(ord_exp[i]));
    end

    // Backpressure: held for 5 cycles, completes on first ready
    do_reset();
    mem_wr_ready = 1'b0;
    pulse_start();
    set_row(2, 32'hABC, 48'h55);
    cyc();
    psum_valid = '0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      check("bp_en", 80'(mem_wr_en), 80'(1));
      check("bp_addr", 80'(mem_wr_addr), 80'(32'hABC));
      check("bp_data", 80'(mem_wr_data), 80'(48'h55));
      cyc();
    end
    base_log     = wr_log.size();
    mem_wr_ready = 1'b1;
    cyc();
    check("bp_release", 80'(wr_log.size() - base_log), 80'(1));
    last = 1'b1;
    cyc();
    last = 1'b0;
    wait_drained(50, 1'b0);

    // Overflow: 6 pushes into row 1 while stalled (4 in FIFO + 1 in output register)
    do_reset();
    mem_wr_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      set_row(1, 32'h40 + 32'(i), 48'(100 + i));
      cyc();
      if (i == 4) check("ovf_before", 80'(overflow), 80'(0));
    end
    psum_valid = '0;
    check("ovf_after", 80'(overflow), 80'(1));
    base_log     = wr_log.size();
    mem_wr_ready = 1'b1;
    last         = 1'b1;
    cyc();
    last = 1'b0;
    wait_drained(50, 1'b0);
    check("ovf_writes", 80'(wr_log.size() - base_log), 80'(5));
    check("ovf_words", 80'(words_written), 80'(5));

    // Late valid after last: dropped and flagged, pass still completes once
    do_reset();
    mem_wr_ready = 1'b1;
    base_dr      = drained_cnt;
    base_log     = wr_log.size();
    pulse_start();
    set_row(0, 32'h70, 48'd7);
    cyc();
    psum_valid = '0;
    last       = 1'b1;
    cyc();
    last = 1'b0;
    set_row(2, 32'h77, 48'd9);
    cyc();
    psum_valid = '0;
    wait_drained(50, 1'b0);
    cyc();
    seen77 = 1'b0;
    for (int i = base_log; i < wr_log.size(); i++) if (wr_log[i] == 32'h77) seen77 = 1'b1;
    check("late_not_written", 80'(seen77), 80'(0));
    check("late_ovf", 80'(overflow), 80'(1));
    check("late_drained_once", 80'(drained_cnt - base_dr), 80'(1));

    // Reset during flush with two entries still queued
    do_reset();
    mem_wr_ready = 1'b0;
    pulse_start();
    for (int r = 0; r < ROWS; r++) set_row(r, 32'h900 + 32'(r), 48'(r + 1));
    cyc();
    psum_valid = '0;
    last       = 1'b1;
    cyc();
    last = 1'b0;
    cyc();
    check("rstf_busy_pre", 80'(busy), 80'(1));
    base_log = wr_log.size();
    base_dr  = drained_cnt;
    rst      = 1'b1;
    #1;
    check("rstf_en_now", 80'(mem_wr_en), 80'(0));
    check("rstf_busy_now", 80'(busy), 80'(0));
    cyc();
    cyc();
    rst          = 1'b0;
    mem_wr_ready = 1'b1;
    repeat (10) cyc();
    check("rstf_no_writes", 80'(wr_log.size() - base_log), 80'(0));
    check("rstf_no_drained", 80'(drained_cnt - base_dr), 80'(0));

    // Randomized passes
    for (int p = 0; p < 25; p++) begin
      mem_wr_ready = ($urandom_range(0, 3) != 0);
      pulse_start();
      len = $urandom_range(5, 30);
      for (int c = 0; c < len; c++) begin
        mem_wr_ready = ($urandom_range(0, 3) != 0);
        start        = ($urandom_range(0, 15) == 0);
        for (int r = 0; r < ROWS; r++) begin
          psum_addr[r*AW +: AW] = $urandom;
          psums_in[r*PW +: PW]  = {16'($urandom), 32'($urandom)};
        end
        psum_valid = ROWS'($urandom);
        last       = (c == len - 1);
        cyc();
      end
      clear_inputs();
      wait_drained(400, 1'b1);
    end

    cyc();
    check("sb_empty", 80'(exp_q.size()), 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/psum_writeback.md
Name: psum_writeback

Overview:
- Sits at the receiving end of the PE-array controller's psum store interface.
- Captures per-row psum_valid/psum_addr/psum data from the array each cycle into small per-row FIFOs.
- Drains the FIFOs round-robin onto a single BRAM write port with a valid/ready handshake.
- Signals completion once the controller's done has been seen and every captured psum has been written.

Parameters:
- ARRAY_ROWS, 3: number of PE rows / psum lanes.
- PSUM_W, 48: psum data width.
- ADDR_W, 32: BRAM address width.
- FIFO_DEPTH, 4: entries per row FIFO (power of 2, >= 2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a collection pass.
- last  in  1  one-cycle pulse from the controller's done; no further psums follow.
- psums_in  in  ARRAY_ROWS*PSUM_W  row i data at bits [i*PSUM_W +: PSUM_W].
- psum_valid  in  ARRAY_ROWS  bit i: row i psum/address valid this cycle.
- psum_addr  in  ARRAY_ROWS*ADDR_W  row i address at bits [i*ADDR_W +: ADDR_W].
- mem_wr_en  out  1  write request valid.
- mem_wr_addr  out  ADDR_W  write address.
- mem_wr_data  out  PSUM_W  write data.
- mem_wr_ready  in  1  BRAM accepts; transfer occurs when mem_wr_en && mem_wr_ready.
- busy  out  1  high in COLLECT or FLUSH.
- drained  out  1  one-cycle pulse when a pass completes.
- overflow  out  1  sticky; a push hit a full FIFO or psum_valid arrived in FLUSH.
- words_written  out  16  transfers completed this pass; wraps at 2^16.

Behaviour:
- Reset values: all outputs 0, FIFOs empty, state IDLE, round-robin pointer rr = 0. Reset asserted mid-pass drops mem_wr_en immediately and discards all data.
- State machine:
  - IDLE -> COLLECT on start. On that edge, clear overflow and words_written.
  - COLLECT -> FLUSH on last.
  - FLUSH -> DONE when all FIFOs are empty and mem_wr_en is 0.
  - DONE -> IDLE unconditionally. drained = 1 only in DONE.
  - start outside IDLE is ignored.
- Push rules:
  - Push happens only in COLLECT. Row i pushes {psum_addr_i, psum_i} when psum_valid[i] is high.
  - All rows may push in the same cycle.
  - psum_valid asserted in the same cycle as last is still accepted.
  - psum_valid in IDLE or DONE is ignored with no flag.
  - psum_valid in FLUSH is dropped and sets overflow.
- Full FIFO:
  - Push to a full FIFO with no simultaneous pop: entry dropped, overflow set.
  - Push and pop on a full FIFO in the same cycle: legal, no overflow.
- Output register: mem_wr_en/addr/data are registered.
  - If mem_wr_en = 0 or mem_wr_ready = 1, load from the arbiter winner: pop it, set mem_wr_en = 1, rr <= (winner + 1) mod ARRAY_ROWS.
  - If no row has data, mem_wr_en <= 0.
  - While mem_wr_en && !mem_wr_ready, addr/data/en hold stable.
- Arbiter: the first non-empty row scanning rr, rr+1, ... with wrap.
- Latency: psum_valid at cycle t gives the earliest mem_wr_en at cycle t+2 (push edge, then load edge).
- Throughput: one write per cycle while mem_wr_ready is held high.
- words_written increments on each transfer in COLLECT or FLUSH.
- busy = (state == COLLECT || state == FLUSH).

Test Plan:
- Single row, no stall: start, then row0 valid for 3 cycles with addr 0x10, 0x11, 0x12 and data 1, 2, 3, then last, ready = 1. Required: writes (0x10,1), (0x11,2), (0x12,3) in order with mem_wr_en first high at t+2; drained pulses once; words_written = 3; overflow = 0.
- All 3 rows valid in one cycle (addr 0x0/0x100/0x200) with rr = 0. Required: writes in row order 0, 1, 2 on consecutive cycles. Next burst of all rows starts from row 0 again (rr wrapped).
- Backpressure: mem_wr_ready = 0 for 5 cycles with one entry pending. Required: mem_wr_addr/data stable and mem_wr_en = 1 throughout. Write completes on the first ready cycle; no loss.
- Overflow: ready = 0, row1 valid for 6 cycles (FIFO_DEPTH = 4, plus 1 entry in the output register). Required: overflow = 1 after the 6th push. Once ready is released, exactly 5 writes occur and words_written = 5.
- Late valid: psum_valid[2] = 1 one cycle after last. Required: entry not written; overflow = 1; drained still pulses once.
- Reset mid-FLUSH with 2 entries pending: assert rst. Required: mem_wr_en = 0 immediately, state IDLE, no further writes, and no drained pulse.
